sync_fifo_param: RTL
====================

SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 Parameter DATA_W, default 8, data word width in bits (>=1).
REQ-002 Parameter ADDR_W, default 5, log2 of depth; DEPTH = 2**ADDR_W (default 32 entries).
REQ-003 Parameter AF_LEVEL, default 28, almost_full asserts when occupancy >= AF_LEVEL (1..DEPTH).
REQ-004 Parameter AE_LEVEL, default 4, almost_empty asserts when occupancy <= AE_LEVEL (0..DEPTH-1).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rstn  input  1  reset; synchronous and active-low.
REQ-007 wr_en  input  1  write request.
REQ-008 wr_data  input  DATA_W  write word, sampled with wr_en.
REQ-009 rd_en  input  1  read request.
REQ-010 rd_data  output  DATA_W  registered read word.
REQ-011 rd_valid  output  1  rd_data carries a word popped on the previous cycle.
REQ-012 full  output  1  occupancy == DEPTH.
REQ-013 empty  output  1  occupancy == 0.
REQ-014 almost_full  output  1  occupancy >= AF_LEVEL.
REQ-015 almost_empty  output  1  occupancy <= AE_LEVEL.
REQ-016 count  output  ADDR_W+1  current occupancy, 0..DEPTH.
REQ-017 overflow  output  1  one-cycle pulse: write request rejected.
REQ-018 underflow  output  1  one-cycle pulse: read request rejected.

Function
REQ-019 Write accepted when wr_en=1 and full=0; word stored at wr_ptr, wr_ptr increments.
REQ-020 Read accepted when rd_en=1 and empty=0; word at rd_ptr loaded into rd_data at same edge, rd_ptr increments.
REQ-021 Read latency: rd_data/rd_valid valid the cycle after the accepting edge; rd_valid high exactly one cycle per accepted read.
REQ-022 rd_data holds its last value when no read is accepted.
REQ-023 Pointers ADDR_W+1 bits; low ADDR_W bits address memory; MSB is wrap bit; increment wraps modulo 2**(ADDR_W+1).
REQ-024 full = (MSBs differ and low bits equal); empty = (pointers equal); count = wr_ptr - rd_ptr modulo 2**(ADDR_W+1).
REQ-025 Simultaneous accepted write and read: count unchanged, both pointers advance.
REQ-026 wr_en and rd_en together while full: read accepted, write rejected, overflow pulses, count becomes DEPTH-1.
REQ-027 wr_en and rd_en together while empty: write accepted, read rejected, underflow pulses, count becomes 1; no fall-through.
REQ-028 Rejected requests leave pointers, memory and count unchanged.
REQ-029 overflow/underflow registered: high for the cycle following the rejected request only.
REQ-030 All status outputs derived from registered state only; no combinational path from wr_en/rd_en to any output.

Reset
REQ-031 On rising clk with rstn=0: wr_ptr=0, rd_ptr=0, rd_data=0, rd_valid=0, overflow=0, underflow=0.
REQ-032 After reset: empty=1, full=0, count=0, almost_empty=1, almost_full=0.
REQ-033 Reset mid-operation discards all contents; requests in the reset cycle are ignored.
REQ-034 Memory array not reset; contents unobservable until rewritten.

Structure
REQ-035 Shared package fifo_pkg holds default constants DATA_W, ADDR_W, AF_LEVEL, AE_LEVEL.
REQ-036 Storage in sub-module fifo_ram: DEPTH x DATA_W, one sync write port, one sync read port, no reset.
REQ-037 Elaboration error if AF_LEVEL or AE_LEVEL out of range.

Verification
REQ-038 Reset, then 32 writes 0x00..0x1F, no reads -> full=1 after 32nd edge, count=32, almost_full from 28th write.
REQ-039 Full FIFO, wr_en=1 with 0xAA, rd_en=0 -> overflow=1 one cycle, count stays 32, 0xAA never read.
REQ-040 Full FIFO, wr_en=rd_en=1 -> rd_data=0x00 next cycle, rd_valid=1, count=31, overflow=1.
REQ-041 Empty FIFO, rd_en=1 -> underflow=1 one cycle, rd_valid=0, rd_data unchanged.
REQ-042 Continuous wr_en=rd_en=1 for 100 cycles after 3 preloads -> count stays 3, data in order across pointer wrap.
REQ-043 rstn=0 for one edge while count=17 -> count=0, empty=1, rd_valid=0 next cycle; next read of fresh write returns written value.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: default geometry and threshold constants for sync_fifo_param
package fifo_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;
  localparam int AF_LEVEL = 28;
  localparam int AE_LEVEL = 4;
endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: unreset DEPTH x DATA_W storage, one sync write port and one sync read port
module fifo_ram #(
  parameter int DATA_W = fifo_pkg::DATA_W,
  parameter int ADDR_W = fifo_pkg::ADDR_W
)(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] q
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) q <= mem[raddr];
  end
endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with wrap-bit pointers, registered read data and sticky-free status
module sync_fifo_param #(
  parameter int DATA_W = fifo_pkg::DATA_W,
  parameter int ADDR_W = fifo_pkg::ADDR_W,
  parameter int AF_LEVEL = fifo_pkg::AF_LEVEL,
  parameter int AE_LEVEL = fifo_pkg::AE_LEVEL
)(
  input  logic              clk,
  input  logic              rstn,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);
  localparam int DEPTH = 2**ADDR_W;
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_af_range
    $error("sync_fifo_param: AF_LEVEL out of range 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_ae_range
    $error("sync_fifo_param: AE_LEVEL out of range 0..DEPTH-1");
  end
  logic [ADDR_W:0] wr_ptr, rd_ptr;
  logic [DATA_W-1:0] q;
  logic primed, wr_ok, rd_ok;
  assign wr_ok = rstn && wr_en && !full;
  assign rd_ok = rstn && rd_en && !empty;
  assign count = wr_ptr - rd_ptr;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) && (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign almost_full = count >= AF_LEVEL[ADDR_W:0];
  assign almost_empty = count <= AE_LEVEL[ADDR_W:0];
  // RAM output register has no reset, so mask it until the first read after reset
  assign rd_data = primed ? q : '0;
  fifo_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk(clk),
    .we(wr_ok),
    .waddr(wr_ptr[ADDR_W-1:0]),
    .wdata(wr_data),
    .re(rd_ok),
    .raddr(rd_ptr[ADDR_W-1:0]),
    .q(q)
  );
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      rd_valid <= 1'b0;
      overflow <= 1'b0;
      underflow <= 1'b0;
      primed <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + {{ADDR_W{1'b0}}, wr_ok};
      rd_ptr <= rd_ptr + {{ADDR_W{1'b0}}, rd_ok};
      rd_valid <= rd_ok;
      overflow <= wr_en && full;
      underflow <= rd_en && empty;
      primed <= primed || rd_ok;
    end
  end
endmodule
